// File: rtl/breakout_pkg.sv
`default_nettype none
// ============================================================================
// breakout_pkg : shared constants for the breakout ball/paddle/render blocks
// Rev 1.0
// ============================================================================
package breakout_pkg;

  localparam int COORD_W     = 10;
  localparam int SCREEN_W    = 320;
  localparam int SCREEN_H    = 240;
  localparam int START_X_DEF = 160;
  localparam int START_Y_DEF = 200;

  localparam logic [1:0] ST_PARK = 2'd0;
  localparam logic [1:0] ST_MOVE = 2'd1;
  localparam logic [1:0] ST_LOST = 2'd2;

  typedef logic [COORD_W-1:0] coord_t;

endpackage
`default_nettype wire

// File: rtl/move_tick.sv
`default_nettype none
// ============================================================================
// move_tick : free-running divider producing a one-cycle tick every TICK_DIV
//             clocks; clr holds the count at zero and suppresses the tick
// Rev 1.0
// ============================================================================
module move_tick #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/ball_motion.sv
`default_nettype none
// ============================================================================
// ball_motion : ball position/direction tracker with park, move and loss states
// Rev 1.0
// ============================================================================
module ball_motion
  import breakout_pkg::*;
#(
  parameter int X_MIN    = 0,
  parameter int X_MAX    = SCREEN_W,
  parameter int Y_MIN    = 1,
  parameter int Y_MAX    = SCREEN_H,
  parameter int START_X  = START_X_DEF,
  parameter int START_Y  = START_Y_DEF,
  parameter int STEP     = 1,
  parameter int TICK_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               launch,
  input  logic               topbotcol,
  input  logic               LRcol,
  input  logic               paddlecol,
  output logic [COORD_W-1:0] ballx,
  output logic [COORD_W-1:0] bally,
  output logic               dir_x,
  output logic               dir_y,
  output logic               moving,
  output logic               ball_lost
);

  localparam logic [10:0]        STEP_W  = 11'(STEP);
  localparam logic [10:0]        X_MIN_W = 11'(X_MIN);
  localparam logic [10:0]        X_MAX_W = 11'(X_MAX);
  localparam logic [10:0]        Y_MIN_W = 11'(Y_MIN);
  localparam logic [10:0]        Y_MAX_W = 11'(Y_MAX);
  localparam logic [COORD_W-1:0] SX      = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] SY      = COORD_W'(START_Y);

  logic [1:0]  state;
  logic        tb_q, lr_q, pad_q;
  logic        tick;
  logic        dx_new, dy_new;
  logic [10:0] x_ext, y_ext, x_sum, y_sum, x_next, y_next;

  wire tb_rise  = topbotcol & ~tb_q;
  wire lr_rise  = LRcol & ~lr_q;
  wire pad_rise = paddlecol & ~pad_q;
  wire cnt_clr  = (state != ST_MOVE);

  move_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_move_tick (
    .clk   (clk),
    .rst_n (rst),
    .clr   (cnt_clr),
    .tick  (tick)
  );

  // New direction is resolved first so a collision on a tick cycle steers that move.
  always_comb begin
    dx_new = dir_x;
    dy_new = dir_y;
    if (lr_rise) dx_new = ~dir_x;
    if (pad_rise)     dy_new = 1'b0;
    else if (tb_rise) dy_new = 1'b1;

    x_ext = {1'b0, ballx};
    y_ext = {1'b0, bally};
    x_sum = x_ext + STEP_W;
    y_sum = y_ext + STEP_W;

    if (dx_new)                       x_next = (x_sum > X_MAX_W) ? X_MAX_W : x_sum;
    else if (x_ext < X_MIN_W + STEP_W) x_next = X_MIN_W;
    else                              x_next = x_ext - STEP_W;

    if (dy_new)                       y_next = y_sum;
    else if (y_ext < Y_MIN_W + STEP_W) y_next = Y_MIN_W;
    else                              y_next = y_ext - STEP_W;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_PARK;
      ballx     <= SX;
      bally     <= SY;
      dir_x     <= 1'b1;
      dir_y     <= 1'b0;
      moving    <= 1'b0;
      ball_lost <= 1'b0;
      tb_q      <= 1'b0;
      lr_q      <= 1'b0;
      pad_q     <= 1'b0;
    end else begin
      tb_q      <= topbotcol;
      lr_q      <= LRcol;
      pad_q     <= paddlecol;
      ball_lost <= 1'b0;
      case (state)
        ST_PARK: begin
          if (launch) begin
            state  <= ST_MOVE;
            moving <= 1'b1;
            dir_x  <= 1'b1;
            dir_y  <= 1'b0;
          end
        end
        ST_MOVE: begin
          dir_x <= dx_new;
          dir_y <= dy_new;
          if (tick) begin
            ballx <= x_next[COORD_W-1:0];
            bally <= y_next[COORD_W-1:0];
            if (y_next >= Y_MAX_W) begin
              state     <= ST_LOST;
              moving    <= 1'b0;
              ball_lost <= 1'b1;
            end
          end
        end
        ST_LOST: begin
          state <= ST_PARK;
          ballx <= SX;
          bally <= SY;
        end
        default: begin
          state  <= ST_PARK;
          moving <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ball_motion.sv
`default_nettype none
// ============================================================================
// tb_ball_motion : vector table, directed corner sequences and random stimulus
//                  compared against a cycle-level behavioural model
// Rev 1.0
// ============================================================================
module tb_ball_motion;

  localparam int TD = 4;
  localparam int ST = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic launch = 1'b0, topbotcol = 1'b0, LRcol = 1'b0, paddlecol = 1'b0;
  logic [9:0] ballx, bally;
  logic dir_x, dir_y, moving, ball_lost;

  int checks = 0;
  int errors = 0;

  ball_motion #(.STEP(ST), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .launch(launch), .topbotcol(topbotcol), .LRcol(LRcol),
    .paddlecol(paddlecol), .ballx(ballx), .bally(bally), .dir_x(dir_x),
    .dir_y(dir_y), .moving(moving), .ball_lost(ball_lost));

  always #5 clk = ~clk;

  // Behavioural model: plain integers, mode names, modulo tick phase.
  localparam int M_PARK = 10, M_MOVE = 11, M_LOST = 12;
  int m_mode, m_x, m_y, m_phase;
  bit m_dx, m_dy, m_lost, m_ptb, m_plr, m_ppad;

  function automatic void model_reset();
    m_mode = M_PARK; m_x = 160; m_y = 200; m_phase = 0;
    m_dx = 1; m_dy = 0; m_lost = 0; m_ptb = 0; m_plr = 0; m_ppad = 0;
  endfunction

  function automatic void model_clock(input bit l, input bit t, input bit lr, input bit p);
    bit r_t, r_lr, r_p;
    r_t = t && !m_ptb; r_lr = lr && !m_plr; r_p = p && !m_ppad;
    m_ptb = t; m_plr = lr; m_ppad = p;
    m_lost = 0;
    if (m_mode == M_PARK) begin
      if (l) begin m_mode = M_MOVE; m_phase = 0; m_dx = 1; m_dy = 0; end
    end else if (m_mode == M_MOVE) begin
      if (r_lr) m_dx = !m_dx;
      if (r_p) m_dy = 0;
      else if (r_t) m_dy = 1;
      if (m_phase == TD - 1) begin
        m_x = m_dx ? ((m_x + ST > 320) ? 320 : m_x + ST) : ((m_x - ST < 0) ? 0 : m_x - ST);
        m_y = m_dy ? m_y + ST : ((m_y - ST < 1) ? 1 : m_y - ST);
        if (m_y >= 240) begin m_mode = M_LOST; m_lost = 1; end
      end
      m_phase = (m_phase + 1) % TD;
    end else begin
      m_mode = M_PARK; m_x = 160; m_y = 200;
    end
  endfunction

  function automatic logic [23:0] dut_vec();
    return {ballx, bally, dir_x, dir_y, moving, ball_lost};
  endfunction

  function automatic logic [23:0] model_vec();
    return {10'(m_x), 10'(m_y), m_dx, m_dy, (m_mode == M_MOVE), m_lost};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit l, input bit t, input bit lr, input bit p);
    @(negedge clk);
    launch = l; topbotcol = t; LRcol = lr; paddlecol = p;
    @(posedge clk);
    model_clock(l, t, lr, p);
    #1;
    check("model", 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; launch = 0; topbotcol = 0; LRcol = 0; paddlecol = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset state", 32'(dut_vec()), 32'({10'd160, 10'd200, 4'b1000}));
  endtask

  task automatic run_to_tick();
    int n = 0;
    while (m_phase != TD - 1 && n < 10) begin step(0, 0, 0, 0); n++; end
    if (n >= 10) check("tick timeout", 1, 0);
  endtask

  typedef struct {
    bit l, t, lr, p;
    logic [9:0] x, y;
    logic dx, dy, mv, lost;
  } vec_t;
  vec_t tbl[14];

  function automatic vec_t mk(bit l, bit lr, int x, int y, bit dx);
    vec_t v;
    v.l = l; v.t = 0; v.lr = lr; v.p = 0;
    v.x = 10'(x); v.y = 10'(y); v.dx = dx; v.dy = 0; v.mv = 1; v.lost = 0;
    return v;
  endfunction

  initial begin
    int n;
    tbl[0]  = mk(1, 0, 160, 200, 1);
    tbl[1]  = mk(0, 0, 160, 200, 1);
    tbl[2]  = mk(0, 0, 160, 200, 1);
    tbl[3]  = mk(0, 0, 160, 200, 1);
    tbl[4]  = mk(0, 0, 161, 199, 1);
    tbl[5]  = mk(0, 0, 161, 199, 1);
    tbl[6]  = mk(0, 0, 161, 199, 1);
    tbl[7]  = mk(0, 0, 161, 199, 1);
    tbl[8]  = mk(0, 0, 162, 198, 1);
    tbl[9]  = mk(0, 1, 162, 198, 0);
    tbl[10] = mk(0, 1, 162, 198, 0);
    tbl[11] = mk(0, 1, 162, 198, 0);
    tbl[12] = mk(0, 1, 161, 197, 0);
    tbl[13] = mk(0, 0, 161, 197, 0);

    // Launch, first ticks and a held LRcol flipping dir_x only once.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].l, tbl[i].t, tbl[i].lr, tbl[i].p);
      check($sformatf("table[%0d]", i), 32'(dut_vec()),
            32'({tbl[i].x, tbl[i].y, tbl[i].dx, tbl[i].dy, tbl[i].mv, tbl[i].lost}));
    end

    // Top clamp, topbotcol bounce, and simultaneous top+paddle on a tick.
    do_reset();
    step(1, 0, 0, 0);
    n = 0;
    while (bally != 10'd1 && n < 1200) begin step(0, 0, 0, 0); n++; end
    check("reach top", 32'(bally), 32'd1);
    check("x right clamp", 32'(ballx), 32'd320);
    run_to_tick();
    step(0, 0, 0, 0);
    check("y top clamp", 32'(bally), 32'd1);
    step(0, 1, 0, 0);
    check("topbot sets dir_y", 32'(dir_y), 32'd1);
    run_to_tick();
    step(0, 0, 0, 0);
    check("bounce y", 32'(bally), 32'd2);
    run_to_tick();
    step(0, 1, 0, 1);
    check("paddle wins dir", 32'(dir_y), 32'd0);
    check("paddle wins y", 32'(bally), 32'd1);

    // Loss off the bottom edge and collision immunity in PARK.
    do_reset();
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    n = 0;
    while (bally != 10'd239 && n < 400) begin step(0, 0, 0, 0); n++; end
    check("reach 239", 32'(bally), 32'd239);
    run_to_tick();
    step(0, 0, 0, 0);
    check("lost pulse", 32'({ball_lost, moving}), 32'b10);
    check("lost y", 32'(bally), 32'd240);
    step(0, 0, 0, 0);
    check("after lost", 32'({ball_lost, moving, ballx, bally}), 32'({2'b00, 10'd160, 10'd200}));
    step(0, 0, 1, 0);
    step(0, 1, 0, 1);
    step(0, 0, 0, 0);
    check("park ignores col", 32'({dir_x, dir_y}), 32'b11);

    // Asynchronous reset between edges, then relaunch.
    do_reset();
    step(1, 0, 0, 0);
    repeat (9) step(0, 0, 0, 0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("async reset", 32'(dut_vec()), 32'({10'd160, 10'd200, 4'b1000}));
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    check("resume", 32'({ballx, bally}), 32'({10'd161, 10'd199}));

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 12) == 0, ($urandom % 10) == 0, ($urandom % 10) == 0, ($urandom % 14) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
